// File: rtl/permutation_controller.sv
// permutation_controller: round scheduler for the ASCON permutation datapath
module permutation_controller #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_mode,
    input  logic       i_hold,
    output logic       o_ready,
    output logic       o_busy,
    output logic [3:0] o_round,
    output logic       o_state_en,
    output logic       o_first_round,
    output logic       o_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [3:0] FIRST_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_B = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] LAST = 4'd11;
    state_t state_q, state_d;
    logic [3:0] round_q, round_d;
    logic first_q, first_d;
    // state, round index and first-round flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            first_q <= first_d;
        end
    end
    // next state: the last round is always index 11, so only the start index depends on mode
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        first_d = first_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = RUN;
                round_d = i_mode ? FIRST_B : FIRST_A;
                first_d = 1'b1;
            end
            RUN: if (!i_hold) begin
                first_d = 1'b0;
                if (round_q == LAST) begin
                    state_d = DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // outputs decoded from registered state; only the round strobes see i_hold
    always_comb begin
        o_ready       = state_q == IDLE;
        o_busy        = state_q == RUN;
        o_done        = state_q == DONE;
        o_round       = o_busy ? round_q : 4'd0;
        o_state_en    = o_busy & ~i_hold;
        o_first_round = o_busy & first_q & ~i_hold;
    end
endmodule

// File: tb/tb_permutation_controller.sv
// tb_permutation_controller: scoreboard bench for the permutation round scheduler
module tb_permutation_controller;
    localparam int NA = 12;
    localparam int NB = 6;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic i_start = 1'b0, i_mode = 1'b0, i_hold = 1'b0;
    logic o_ready, o_busy, o_state_en, o_first_round, o_done;
    logic [3:0] o_round;
    int n_cmp = 0, n_bad = 0;
    logic [8:0] exp_q[$];
    // reference model: counts remaining rounds instead of comparing against a last index
    logic m_busy = 1'b0, m_first = 1'b0, m_done = 1'b0;
    int m_idx = 0, m_left = 0;
    int done_cnt = 0;

    permutation_controller #(.NB_ROUNDS_A(NA), .NB_ROUNDS_B(NB)) dut (
        .clock(clock), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_hold(i_hold),
        .o_ready(o_ready), .o_busy(o_busy), .o_round(o_round), .o_state_en(o_state_en),
        .o_first_round(o_first_round), .o_done(o_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy/busy/rnd/en/first/done=%b_%b_%0d_%b_%b_%b want %b_%b_%0d_%b_%b_%b",
                     tag, obs[8], obs[7], obs[6:3], obs[2], obs[1], obs[0],
                     exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {o_ready, o_busy, o_round, o_state_en, o_first_round, o_done};
    endfunction

    function automatic logic [8:0] model_vec(input logic hold);
        logic idle;
        logic [3:0] r;
        idle = !m_busy && !m_done;
        r = m_busy ? 4'(m_idx) : 4'd0;
        return {idle, m_busy, r, m_busy & ~hold, m_busy & m_first & ~hold, m_done};
    endfunction

    task automatic step(input string tag, input logic st, input logic md, input logic hd);
        logic [8:0] e;
        @(negedge clock);
        i_start = st;
        i_mode = md;
        i_hold = hd;
        exp_q.push_back(model_vec(hd));
        #1;
        e = exp_q.pop_front();
        check(tag, dut_vec(), e);
        if (o_done) done_cnt++;
        @(posedge clock);
        if (m_done) m_done = 1'b0;
        else if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1;
                m_left = md ? NB : NA;
                m_idx = 12 - m_left;
                m_first = 1'b1;
            end
        end else if (!hd) begin
            m_first = 1'b0;
            if (m_left == 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
                m_left--;
            end
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clock);
        i_start = 1'b0;
        i_hold = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_busy = 1'b0;
        m_first = 1'b0;
        m_done = 1'b0;
        m_idx = 0;
        check(tag, dut_vec(), model_vec(1'b0));
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset", dut_vec(), 9'b1_0_0000_0_0_0);
        @(negedge clock);
        reset = 1'b0;
        step("idle", 0, 0, 1);
        // full p^a
        step("pa_start", 1, 0, 0);
        for (int i = 0; i < 14; i++) step("pa_run", 0, 0, 0);
        // p^b
        step("pb_start", 1, 1, 0);
        for (int i = 0; i < 8; i++) step("pb_run", 0, 1, 0);
        // p^a with holds at cycles 1 and 5
        step("hold_start", 1, 0, 0);
        for (int c = 1; c <= 16; c++) step("hold_run", 0, 0, c == 1 || c == 5);
        // start held high continuously: done once per permutation
        done_cnt = 0;
        for (int i = 0; i < 3 * (NB + 2); i++) step("start_hi", 1, 1, 0);
        for (int i = 0; i < 3; i++) step("start_hi_tail", 0, 1, 0);
        check("done_count", 9'(done_cnt), 9'd3);
        // reset in the middle of a p^a run
        step("rst_start", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("rst_run", 0, 0, 0);
        async_reset("async_rst");
        done_cnt = 0;
        for (int i = 0; i < 3; i++) step("post_rst_idle", 0, 0, 0);
        check("no_done_after_rst", 9'(done_cnt), 9'd0);
        step("post_rst_pb", 1, 1, 0);
        for (int i = 0; i < 8; i++) step("post_rst_run", 0, 0, 0);
        // mode toggling during a run has no effect
        step("mode_start", 1, 1, 0);
        for (int i = 0; i < 9; i++) step("mode_toggle", 0, i[0], 0);
        // random traffic
        for (int i = 0; i < 300; i++)
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
